// File: rtl/evt_window_counter_if.sv
// Host-side control/status bundle for evt_window_counter.
// master: host endpoint (trigger-in / wire-in drive, wire-out / trigger-out read).
// slave : the counter block itself.
interface evt_window_counter_if #(
   parameter int CW = 16,
   parameter int WW = 24
);
   logic          arm;
   logic          clear;
   logic [WW-1:0] window_len;
   logic [CW-1:0] count_out;
   logic          busy;
   logic          done_pulse;
   logic          ovf_pulse;
   logic          ovf_flag;

   modport master (
      output arm, clear, window_len,
      input  count_out, busy, done_pulse, ovf_pulse, ovf_flag
   );

   modport slave (
      input  arm, clear, window_len,
      output count_out, busy, done_pulse, ovf_pulse, ovf_flag
   );
endinterface

// File: rtl/evt_window_counter.sv
// Gated event counter: counts edges of an asynchronous input over a
// host-programmed window of sys_clk cycles and reports the result.
// Optional feature macro: EVT_WINDOW_BOTH_EDGES_EN (count rising and falling
// transitions); default build counts rising edges only.
module evt_window_counter #(
   parameter int CW          = 16,
   parameter int WW          = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  sys_clk,
   input  logic                  reset,
   input  logic                  evt_in,
   evt_window_counter_if.slave   bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [CW-1:0] ACC_MAX = {CW{1'b1}};
   localparam logic [WW-1:0] WIN_ONE = WW'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [0:0]             state_q, state_d;
   logic [WW-1:0]          win_cnt_q, win_cnt_d;
   logic [CW-1:0]          acc_q, acc_d;
   logic [CW-1:0]          count_out_q, count_out_d;
   logic                   busy_q, busy_d;
   logic                   done_pulse_q, done_pulse_d;
   logic                   ovf_pulse_q, ovf_pulse_d;
   logic                   ovf_flag_q, ovf_flag_d;

   logic                   evt_s;
   logic                   evt_edge;
   logic [CW-1:0]          acc_upd;
   logic                   ovf_upd;
   logic                   ovf_first;

   // Synchroniser shift and edge-detect history
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
      evt_s  = sync_q[SYNC_STAGES-1];
      prev_d = evt_s;
`ifdef EVT_WINDOW_BOTH_EDGES_EN
      evt_edge = evt_s ^ prev_q;
`else
      evt_edge = evt_s & ~prev_q;
`endif
   end

   // Saturating accumulator step for the current cycle's edge
   always_comb begin
      acc_upd   = acc_q;
      ovf_upd   = 1'b0;
      ovf_first = 1'b0;
      if (evt_edge) begin
         if (acc_q == ACC_MAX) begin
            ovf_upd   = 1'b1;
            ovf_first = ~ovf_flag_q;
         end else begin
            acc_upd = acc_q + CW'(1);
         end
      end
   end

   // Window FSM: clear beats arm, arm beats counting/completion
   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q;
      acc_d        = acc_q;
      count_out_d  = count_out_q;
      ovf_flag_d   = ovf_flag_q;
      done_pulse_d = 1'b0;
      ovf_pulse_d  = 1'b0;

      if (bus.clear) begin
         state_d     = IDLE;
         win_cnt_d   = '0;
         acc_d       = '0;
         count_out_d = '0;
         ovf_flag_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // A zero-length arm is ignored entirely while idle
               if (bus.arm && (bus.window_len != '0)) begin
                  state_d    = RUN;
                  win_cnt_d  = bus.window_len;
                  acc_d      = '0;
                  ovf_flag_d = 1'b0;
               end
            end
            RUN: begin
               if (bus.arm) begin
                  // Restart: discard the running window without reporting it
                  acc_d      = '0;
                  ovf_flag_d = 1'b0;
                  if (bus.window_len != '0) begin
                     win_cnt_d = bus.window_len;
                  end else begin
                     win_cnt_d = '0;
                     state_d   = IDLE;
                  end
               end else begin
                  win_cnt_d   = win_cnt_q - WIN_ONE;
                  acc_d       = acc_upd;
                  ovf_pulse_d = ovf_first;
                  if (ovf_upd) begin
                     ovf_flag_d = 1'b1;
                  end
                  // Last window cycle: the edge of this cycle is included
                  if (win_cnt_q == WIN_ONE) begin
                     count_out_d  = acc_upd;
                     done_pulse_d = 1'b1;
                     state_d      = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d == RUN);
   end

   // State registers with synchronous reset
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         sync_q       <= '0;
         prev_q       <= 1'b0;
         state_q      <= IDLE;
         win_cnt_q    <= '0;
         acc_q        <= '0;
         count_out_q  <= '0;
         busy_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         ovf_pulse_q  <= 1'b0;
         ovf_flag_q   <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         state_q      <= state_d;
         win_cnt_q    <= win_cnt_d;
         acc_q        <= acc_d;
         count_out_q  <= count_out_d;
         busy_q       <= busy_d;
         done_pulse_q <= done_pulse_d;
         ovf_pulse_q  <= ovf_pulse_d;
         ovf_flag_q   <= ovf_flag_d;
      end
   end

   assign bus.count_out  = count_out_q;
   assign bus.busy       = busy_q;
   assign bus.done_pulse = done_pulse_q;
   assign bus.ovf_pulse  = ovf_pulse_q;
   assign bus.ovf_flag   = ovf_flag_q;

endmodule

// File: tb/tb_evt_window_counter.sv
// Directed bench for evt_window_counter: a default-width instance and a
// CW=4 instance share the same stimulus; the narrow one exercises overflow.
module tb_evt_window_counter;

`ifdef EVT_WINDOW_BOTH_EDGES_EN
   localparam int BOTH = 1;
`else
   localparam int BOTH = 0;
`endif

   logic        clk;
   logic        reset;
   logic        evt;
   logic        arm;
   logic        clr;
   logic [23:0] wlen;

   int checks;
   int failures;

   int done_cnt, done_at, busy_cnt, ovf_cnt, ovf_at;
   logic [31:0] mid_count;
   int bad;

   evt_window_counter_if #(.CW(16), .WW(24)) bus_a ();
   evt_window_counter_if #(.CW(4),  .WW(24)) bus_b ();

   assign bus_a.arm        = arm;
   assign bus_a.clear      = clr;
   assign bus_a.window_len = wlen;
   assign bus_b.arm        = arm;
   assign bus_b.clear      = clr;
   assign bus_b.window_len = wlen;

   evt_window_counter #(.CW(16), .WW(24), .SYNC_STAGES(2)) dut_a (
      .sys_clk (clk),
      .reset   (reset),
      .evt_in  (evt),
      .bus     (bus_a.slave)
   );

   evt_window_counter #(.CW(4), .WW(24), .SYNC_STAGES(2)) dut_b (
      .sys_clk (clk),
      .reset   (reset),
      .evt_in  (evt),
      .bus     (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // Arm a window of len cycles, then step total cycles. Index j is the
   // negedge after the j-th posedge following the arm sample.
   task automatic run_window(input int len, input int total, input int rearm_at,
                             input int clear_at, input int wave_end, input int mid_at);
      @(negedge clk);
      arm  = 1'b1;
      wlen = len[23:0];
      done_cnt = 0; done_at = -1; busy_cnt = 0; ovf_cnt = 0; ovf_at = -1;
      mid_count = 32'hFFFF_FFFF;
      for (int j = 0; j < total; j++) begin
         @(negedge clk);
         arm = 1'b0;
         clr = 1'b0;
         if (j == rearm_at) arm = 1'b1;
         if (j == clear_at) clr = 1'b1;
         evt = (j < wave_end) && ((j % 10) >= 1) && ((j % 10) <= 5);
         if (bus_a.busy) busy_cnt++;
         if (bus_a.done_pulse) begin done_cnt++; done_at = j; end
         if (bus_b.ovf_pulse) begin ovf_cnt++; ovf_at = j; end
         if (j == mid_at) mid_count = 32'(bus_a.count_out);
      end
      arm = 1'b0;
      clr = 1'b0;
      evt = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; evt = 1'b1; arm = 1'b0; clr = 1'b0; wlen = '0;

      // Reset with evt high
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_count",  32'(bus_a.count_out),  0);
      chk("rst_busy",   32'(bus_a.busy),       0);
      chk("rst_done",   32'(bus_a.done_pulse), 0);
      chk("rst_ovfp",   32'(bus_a.ovf_pulse),  0);
      chk("rst_ovff",   32'(bus_a.ovf_flag),   0);
      reset = 1'b0;

      // Idle activity without arm must not count or pulse
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         evt = ((i / 5) % 2) == 1;
         if (bus_a.busy || bus_a.done_pulse || bus_a.ovf_pulse || bus_a.count_out != 0) bad++;
      end
      chk("idle_activity", 32'(bad), 0);
      evt = 1'b0;
      repeat (5) @(negedge clk);

      // Basic 100-cycle window, square wave period 10
      run_window(100, 105, -1, -1, 100, -1);
      chk("basic_busy_cycles", 32'(busy_cnt), 100);
      chk("basic_done_cnt",    32'(done_cnt), 1);
      chk("basic_done_at",     32'(done_at),  100);
      chk("basic_count",       32'(bus_a.count_out), 32'(10 * (1 + BOTH)));

      // Re-arm at cycle 30: only edges after the second arm count
      run_window(100, 140, 29, -1, 100, 100);
      chk("rearm_count_hold",  mid_count, 32'(10 * (1 + BOTH)));
      chk("rearm_done_cnt",    32'(done_cnt), 1);
      chk("rearm_done_at",     32'(done_at),  130);
      chk("rearm_count",       32'(bus_a.count_out), 32'(7 * (1 + BOTH)));

      // Zero-length arm is ignored
      run_window(0, 20, -1, -1, 0, -1);
      chk("zero_busy_cycles",  32'(busy_cnt), 0);
      chk("zero_done_cnt",     32'(done_cnt), 0);
      chk("zero_count_hold",   32'(bus_a.count_out), 32'(7 * (1 + BOTH)));

      // Single-cycle window with an edge landing in that cycle
      @(negedge clk); evt = 1'b1;
      @(negedge clk); arm = 1'b1; wlen = 24'd1;
      @(negedge clk); arm = 1'b0;
      chk("len1_busy",  32'(bus_a.busy),       1);
      chk("len1_nodone",32'(bus_a.done_pulse), 0);
      @(negedge clk);
      chk("len1_done",  32'(bus_a.done_pulse), 1);
      chk("len1_count", 32'(bus_a.count_out),  1);
      chk("len1_idle",  32'(bus_a.busy),       0);
      evt = 1'b0;
      repeat (5) @(negedge clk);

      // Abort with clear at cycle 40
      run_window(100, 110, -1, 39, 100, -1);
      chk("abort_busy_cycles", 32'(busy_cnt), 40);
      chk("abort_done_cnt",    32'(done_cnt), 0);
      chk("abort_count",       32'(bus_a.count_out), 0);

      // clear and arm together: clear wins
      @(negedge clk); arm = 1'b1; clr = 1'b1; wlen = 24'd100;
      @(negedge clk); arm = 1'b0; clr = 1'b0;
      chk("clrarm_busy", 32'(bus_a.busy), 0);
      repeat (5) @(negedge clk);
      chk("clrarm_busy_later", 32'(bus_a.busy), 0);

      // Overflow on the CW=4 instance: 20 rising edges in a 500-cycle window
      run_window(500, 502, -1, -1, 200, -1);
      chk("ovf_pulse_cnt", 32'(ovf_cnt), 1);
      chk("ovf_pulse_at",  32'(ovf_at),  (BOTH != 0) ? 32'd79 : 32'd154);
      chk("ovf_count",     32'(bus_b.count_out), 15);
      chk("ovf_flag_after",32'(bus_b.ovf_flag),  1);
      chk("ovf_wide_count",32'(bus_a.count_out), 32'(20 * (1 + BOTH)));
      chk("ovf_wide_flag", 32'(bus_a.ovf_flag),  0);

      // Next accepted arm clears the sticky flag
      run_window(10, 12, -1, -1, 0, -1);
      chk("ovf_flag_rearm", 32'(bus_b.ovf_flag), 0);
      chk("ovf_rearm_done", 32'(done_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/evt_window_counter.md
Name: evt_window_counter

Overview:
- Gated event counter: measures activity on an external asynchronous input over a host-programmed window of sys_clk cycles.
- Complements the free-running clock-divided counters. Those generate counts and report them to the host; this block takes count events in from outside and reports the result to the host.
- Control pulses come from a trigger-in endpoint and the window length from a wire-in.
- count_out feeds a wire-out; done_pulse and ovf_pulse feed a trigger-out.

Parameters:
- CW, 16, width of the event accumulator and of count_out.
- WW, 24, width of window_len and of the internal window down-counter.
- SYNC_STAGES, 2, flip-flop stages in the evt_in synchroniser (legal values ≥ 2).

Ports:
- sys_clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- evt_in  in  1  external asynchronous event input.
- arm  in  1  single-cycle pulse (trigger-in): start a measurement window.
- clear  in  1  single-cycle pulse (trigger-in): abort the window and clear all results.
- window_len  in  WW  window length in sys_clk cycles; sampled only when arm is accepted.
- count_out  out  CW  result of the last completed window.
- busy  out  1  high while a window is running.
- done_pulse  out  1  one-cycle pulse when a window completes.
- ovf_pulse  out  1  one-cycle pulse on the first saturating event in a window.
- ovf_flag  out  1  sticky overflow indicator.

Behaviour:
- Reset (synchronous, active-high): state IDLE; synchroniser, edge register, accumulator, window counter, count_out, busy, done_pulse, ovf_pulse and ovf_flag all 0.
- Synchroniser: evt_in passes through SYNC_STAGES flip-flops; the result is evt_s.
- Edge detect: prev <= evt_s; edge = evt_s & ~prev.
  - Latency from an evt_in transition to the accumulator increment: SYNC_STAGES+1 cycles.
- FSM, two states, IDLE and RUN:
  - IDLE, arm=1 and window_len≠0 → RUN. Load win_cnt <= window_len, acc <= 0, ovf_flag <= 0.
  - IDLE, arm=1 and window_len=0 → arm ignored; stay in IDLE; no output change.
  - RUN, every cycle: win_cnt <= win_cnt-1. If edge, acc <= acc+1, saturating at 2^CW-1.
  - RUN, edge while acc = 2^CW-1:
    - ovf_flag <= 1.
    - ovf_pulse = 1 for one cycle, only if ovf_flag was 0 in this window.
    - acc holds.
  - RUN, win_cnt=1: last window cycle.
    - count_out <= acc, including an edge in this cycle.
    - done_pulse = 1 for one cycle.
    - → IDLE.
  - Window timing: arm sampled at edge k → RUN covers edges k+1 … k+N (N = window_len) → done_pulse and the new count_out are visible after edge k+N.
  - RUN, arm=1 (re-arm): restart. Reload win_cnt from window_len (0 → go to IDLE), acc <= 0, ovf_flag <= 0. No done_pulse; count_out unchanged.
- clear, any state: → IDLE.
  - acc, count_out, ovf_flag <= 0. No done_pulse.
  - clear has priority over arm in the same cycle.
  - clear has priority over window completion in the same cycle (no done_pulse, count_out = 0).
- busy = (state == RUN), registered.
- count_out holds its value until the next completion, clear, or reset.
- ovf_flag stays set after a window ends until the next accepted arm, clear, or reset.
- Width rules:
  - acc is CW bits and never wraps.
  - win_cnt is WW bits; the maximum window is 2^WW-1 cycles.

Optional Feature:
- Macro: EVT_WINDOW_BOTH_EDGES_EN.
- Defined: edge = evt_s ^ prev, so rising and falling transitions each count. Saturation and overflow rules are unchanged.
- Undefined: only rising edges count.

Test Plan:
- Reset: drive evt_in high and assert reset for 3 cycles → all outputs 0, busy 0. With no arm, no count and no pulses for 50 cycles.
- Basic window: evt_in square wave, period 10 cycles; window_len=100; arm pulse → busy high for exactly 100 cycles; done_pulse once, 100 edges after arm; count_out=10. Macro defined → count_out=20.
- Overflow: CW=4; 20 rising edges inside a window_len=500 window → count_out=15; ovf_pulse exactly once (on the 16th edge); ovf_flag=1 after done. Next arm → ovf_flag=0.
- Abort: clear at cycle 40 of a 100-cycle window → busy 0 on the next cycle, no done_pulse, count_out=0. Also clear and arm asserted together → stays IDLE.
- Re-arm: arm at cycle 30 of a 100-cycle window → no done_pulse at cycle 100; done_pulse 100 cycles after the second arm; count reflects only the edges after the second arm.
- Zero length and boundaries:
  - arm with window_len=0 → busy stays 0, no done_pulse, count_out unchanged.
  - window_len=1 with evt_s edge in the single cycle → count_out=1, done_pulse one cycle after arm.
